// File: rtl/noc_output_scheduler_pkg.sv
// Shared router definitions: flit-id encoding, port indices, scheduler state enum.
// Also reused by the VC allocator, hence the generic noc_pkg name.
package noc_pkg;
    localparam int NPORTS = 5;
    localparam int PORT_L = 0;
    localparam int PORT_N = 1;
    localparam int PORT_E = 2;
    localparam int PORT_W = 3;
    localparam int PORT_S = 4;

    localparam int FID_HEAD = 0;
    localparam int FID_BODY = 1;
    localparam int FID_TAIL = 2;

    localparam logic [2:0] FLIT_HEAD = 3'b001;
    localparam logic [2:0] FLIT_BODY = 3'b010;
    localparam logic [2:0] FLIT_TAIL = 3'b100;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_e;

    // BODY may never be combined with another bit; all-zero is not a flit
    function automatic logic flit_valid(logic [2:0] id);
        return (id != 3'b000) && !(id[FID_BODY] && ((id & ~FLIT_BODY) != 3'b000));
    endfunction

    function automatic logic flit_head_ok(logic [2:0] id);
        return flit_valid(id) && id[FID_HEAD];
    endfunction
endpackage

// File: rtl/noc_output_scheduler_if.sv
// Handshake bundle between the input ports / downstream link and one output scheduler.
interface noc_output_scheduler_if #(
    parameter int CW = 3
);
    import noc_pkg::*;

    logic [NPORTS-1:0]   req;
    logic [3*NPORTS-1:0] flit_id;
    logic                credit_in;
    logic [NPORTS-1:0]   gnt;
    logic [2:0]          gnt_idx;
    logic                fire;
    logic                busy;
    logic                abort;
    logic [CW-1:0]       credit_cnt;
    logic                credit_err;

    modport master (
        output req, flit_id, credit_in,
        input  gnt, gnt_idx, fire, busy, abort, credit_cnt, credit_err
    );

    modport slave (
        input  req, flit_id, credit_in,
        output gnt, gnt_idx, fire, busy, abort, credit_cnt, credit_err
    );
endinterface

// File: rtl/noc_output_scheduler_rr_picker.sv
// Combinational round-robin picker: first set bit of elig at or after ptr, wrapping.
module noc_rr_picker
    import noc_pkg::*;
(
    input  logic [NPORTS-1:0] elig,
    input  logic [2:0]        ptr,
    output logic [NPORTS-1:0] pick,
    output logic [2:0]        pick_idx,
    output logic              any
);
    int p;

    always_comb begin
        pick     = '0;
        pick_idx = '0;
        any      = 1'b0;
        p        = 0;
        for (int i = 0; i < NPORTS; i++) begin
            p = (int'(ptr) + i) % NPORTS;
            if (!any && elig[p]) begin
                any      = 1'b1;
                pick[p]  = 1'b1;
                pick_idx = 3'(p);
            end
        end
    end
endmodule

// File: rtl/noc_output_scheduler.sv
// Output-port scheduler: round-robin packet lock, credit flow control, stall watchdog.
//   state | meaning
//   IDLE  | no grant; pick the next eligible HEAD
//   LOCK  | port gnt_idx owns the link until its TAIL fires or the watchdog trips
module noc_output_scheduler
    import noc_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int CW      = 3,
    parameter int TIMEOUT = 255
) (
    input logic clk,
    input logic rst,
    noc_output_scheduler_if.slave bus
);
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [11:0]   TIMEOUT_C = 12'(TIMEOUT);

    state_e            state_q, state_d;
    logic [NPORTS-1:0] gnt_q, gnt_d;
    logic [2:0]        gnt_idx_q, gnt_idx_d;
    logic [2:0]        rr_ptr_q, rr_ptr_d;
    logic              abort_q, abort_d;
    logic [11:0]       stall_cnt_q, stall_cnt_d;
    logic [CW-1:0]     credit_cnt_q, credit_cnt_d;
    logic              credit_err_q, credit_err_d;

    logic [NPORTS-1:0] elig, pick;
    logic [2:0]        pick_idx, next_ptr;
    logic              any, cur_req, fire;
    logic [2:0]        cur_id;

    always_comb begin
        elig    = '0;
        cur_req = 1'b0;
        cur_id  = '0;
        for (int p = 0; p < NPORTS; p++) begin
            elig[p] = bus.req[p] && flit_head_ok(bus.flit_id[3*p +: 3]);
            if (gnt_idx_q == 3'(p)) begin
                cur_req = bus.req[p];
                cur_id  = bus.flit_id[3*p +: 3];
            end
        end
    end

    noc_rr_picker u_picker (
        .elig     (elig),
        .ptr      (rr_ptr_q),
        .pick     (pick),
        .pick_idx (pick_idx),
        .any      (any)
    );

    assign fire     = (state_q == LOCK) && cur_req && (credit_cnt_q != '0);
    assign next_ptr = (gnt_idx_q == 3'(NPORTS-1)) ? 3'd0 : gnt_idx_q + 3'd1;

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        rr_ptr_d    = rr_ptr_q;
        abort_d     = 1'b0;
        stall_cnt_d = stall_cnt_q;
        case (state_q)
            IDLE: begin
                if (any) begin
                    state_d     = LOCK;
                    gnt_d       = pick;
                    gnt_idx_d   = pick_idx;
                    stall_cnt_d = '0;
                end
            end
            LOCK: begin
                if (fire) begin
                    stall_cnt_d = '0;
                    if (cur_id[FID_TAIL]) begin
                        state_d  = IDLE;
                        gnt_d    = '0;
                        rr_ptr_d = next_ptr;
                    end
                end else if (stall_cnt_q == TIMEOUT_C) begin
                    state_d     = IDLE;
                    gnt_d       = '0;
                    rr_ptr_d    = next_ptr;
                    abort_d     = 1'b1;
                    stall_cnt_d = '0;
                end else begin
                    stall_cnt_d = stall_cnt_q + 12'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A simultaneous fire and credit return cancel out
    always_comb begin
        credit_cnt_d = credit_cnt_q;
        credit_err_d = credit_err_q || (bus.credit_in && (credit_cnt_q == DEPTH_C));
        if (fire && !bus.credit_in)
            credit_cnt_d = credit_cnt_q - CW'(1);
        else if (!fire && bus.credit_in && (credit_cnt_q != DEPTH_C))
            credit_cnt_d = credit_cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            gnt_q        <= '0;
            gnt_idx_q    <= '0;
            rr_ptr_q     <= '0;
            abort_q      <= 1'b0;
            stall_cnt_q  <= '0;
            credit_cnt_q <= DEPTH_C;
            credit_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            gnt_idx_q    <= gnt_idx_d;
            rr_ptr_q     <= rr_ptr_d;
            abort_q      <= abort_d;
            stall_cnt_q  <= stall_cnt_d;
            credit_cnt_q <= credit_cnt_d;
            credit_err_q <= credit_err_d;
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.gnt_idx    = gnt_idx_q;
    assign bus.fire       = fire;
    assign bus.busy       = (state_q == LOCK);
    assign bus.abort      = abort_q;
    assign bus.credit_cnt = credit_cnt_q;
    assign bus.credit_err = credit_err_q;
endmodule
